// File: rtl/ysyx_22050019_lsu_pkg.sv
// Shared definitions for the load/store unit:
// funct3 encodings, FSM states, error codes and strobe masks.
package ysyx_22050019_defs;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    localparam logic [7:0] STRB_B = 8'h01;
    localparam logic [7:0] STRB_H = 8'h03;
    localparam logic [7:0] STRB_W = 8'h0F;
    localparam logic [7:0] STRB_D = 8'hFF;

    // funct3 = 111 has no valid access size, so it is rejected as misaligned.
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [2:0] off);
        logic bad;
        bad = 1'b1;
        case (f3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = off[0];
            F3_W, F3_WU: bad = |off[1:0];
            F3_D:        bad = |off;
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_22050019_lsu_align.sv
// Combinational lane steering: store strobes/data placement
// and load byte extraction with sign/zero extension.
import ysyx_22050019_defs::*;

module ysyx_22050019_lsu_align (
    input  logic [2:0]  st_funct3,
    input  logic [2:0]  st_off,
    input  logic [63:0] st_data,
    output logic [63:0] st_wdata,
    output logic [7:0]  st_wstrb,
    output logic        st_misaligned,
    input  logic [2:0]  ld_funct3,
    input  logic [2:0]  ld_off,
    input  logic [63:0] ld_rdata,
    output logic [63:0] ld_data
);

    logic [7:0]  base;
    logic [63:0] sh;

    // Store side: size mask and data moved to the addressed byte lane.
    always_comb begin
        base = STRB_B;
        case (st_funct3[1:0])
            2'b00:   base = STRB_B;
            2'b01:   base = STRB_H;
            2'b10:   base = STRB_W;
            default: base = STRB_D;
        endcase
        st_wstrb      = base << st_off;
        st_wdata      = st_data << {st_off, 3'b000};
        st_misaligned = is_misaligned(st_funct3, st_off);
    end

    // Load side: bring the addressed bytes down to bit 0, then extend.
    always_comb begin
        sh = ld_rdata >> {ld_off, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{56{sh[7]}}, sh[7:0]};
            F3_H:    ld_data = {{48{sh[15]}}, sh[15:0]};
            F3_W:    ld_data = {{32{sh[31]}}, sh[31:0]};
            F3_BU:   ld_data = {56'd0, sh[7:0]};
            F3_HU:   ld_data = {48'd0, sh[15:0]};
            F3_WU:   ld_data = {32'd0, sh[31:0]};
            default: ld_data = sh;
        endcase
    end

endmodule

// File: rtl/ysyx_22050019_lsu.sv
// Load/store unit between EX_MEM and MEM_WB: one outstanding
// valid/ready data-memory transaction with timeout and write-back.
import ysyx_22050019_defs::*;

module ysyx_22050019_lsu #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid_i,
    input  logic              mem_wen_i,
    input  logic [2:0]        funct3_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [4:0]        rd_i,
    output logic              dmem_req_valid_o,
    input  logic              dmem_req_ready_i,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic              dmem_wen_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    output logic [7:0]        dmem_wstrb_o,
    input  logic              dmem_resp_valid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              reg_we_lsu_o,
    output logic [4:0]        reg_waddr_lsu_o,
    output logic [DATA_W-1:0] reg_wdata_lsu_o,
    output logic              lsu_stall_o,
    output logic [1:0]        lsu_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_e state, state_n;

    logic [CNT_W-1:0]  cnt;
    logic              wen_q;
    logic [2:0]        f3_q;
    logic [2:0]        off_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wstrb_q;

    logic              misal;
    logic [63:0]       st_wdata;
    logic [7:0]        st_wstrb;
    logic [63:0]       ld_data;

    logic              accept;
    logic              done;
    logic              to_hit;
    logic              to_fire;
    logic              req_valid;
    logic              stall;

    logic              reg_we_q;
    logic [4:0]        waddr_q;
    logic [DATA_W-1:0] rwdata_q;
    logic [1:0]        err_q;

    ysyx_22050019_lsu_align u_align (
        .st_funct3     (funct3_i),
        .st_off        (addr_i[2:0]),
        .st_data       (wdata_i),
        .st_wdata      (st_wdata),
        .st_wstrb      (st_wstrb),
        .st_misaligned (misal),
        .ld_funct3     (f3_q),
        .ld_off        (off_q),
        .ld_rdata      (dmem_rdata_i),
        .ld_data       (ld_data)
    );

    assign to_hit = (TIMEOUT != 0) && (cnt == TO_LAST);
    assign accept = (state == ST_IDLE) && mem_valid_i && !misal;

    // Next state, handshake and stall; a response beats a same-cycle timeout.
    always_comb begin
        state_n   = state;
        req_valid = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        to_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_REQ;
                    stall   = 1'b1;
                end
            end
            ST_REQ: begin
                req_valid = 1'b1;
                stall     = 1'b1;
                if (dmem_req_ready_i) begin
                    state_n = ST_RESP;
                end else if (to_hit) begin
                    state_n = ST_IDLE;
                    to_fire = 1'b1;
                end
            end
            ST_RESP: begin
                if (dmem_resp_valid_i) begin
                    state_n = ST_IDLE;
                    done    = 1'b1;
                end else begin
                    stall = 1'b1;
                    if (to_hit) begin
                        state_n = ST_IDLE;
                        to_fire = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register and per-state wait counter, cleared on every entry.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (state_n != state) begin
                cnt <= '0;
            end else if (state != ST_IDLE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Capture the request fields so they stay stable while waiting for ready.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wen_q   <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            rd_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            wen_q   <= mem_wen_i;
            f3_q    <= funct3_i;
            off_q   <= addr_i[2:0];
            rd_q    <= rd_i;
            addr_q  <= {addr_i[DATA_W-1:3], 3'b000};
            wdata_q <= st_wdata;
            wstrb_q <= st_wstrb;
        end
    end

    // Registered write-back pulse for loads and one-cycle error pulses.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            reg_we_q <= 1'b0;
            waddr_q  <= '0;
            rwdata_q <= '0;
            err_q    <= ERR_NONE;
        end else begin
            reg_we_q <= done && !wen_q;
            if (done && !wen_q) begin
                waddr_q  <= rd_q;
                rwdata_q <= ld_data;
            end
            if ((state == ST_IDLE) && mem_valid_i && misal) begin
                err_q <= ERR_MISALIGN;
            end else if (to_fire) begin
                err_q <= ERR_TIMEOUT;
            end else begin
                err_q <= ERR_NONE;
            end
        end
    end

    assign dmem_req_valid_o = req_valid;
    assign dmem_addr_o      = addr_q;
    assign dmem_wen_o       = wen_q;
    assign dmem_wdata_o     = wdata_q;
    assign dmem_wstrb_o     = wstrb_q;
    assign reg_we_lsu_o     = reg_we_q;
    assign reg_waddr_lsu_o  = waddr_q;
    assign reg_wdata_lsu_o  = rwdata_q;
    assign lsu_stall_o      = stall;
    assign lsu_err_o        = err_q;

endmodule

// File: tb/tb_ysyx_22050019_lsu.sv
// Self-checking bench for the LSU: directed scenarios plus a
// randomized load/store stream against a byte-array memory model.
module tb_ysyx_22050019_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid_i;
    logic        mem_wen_i;
    logic [2:0]  funct3_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [4:0]  rd_i;
    logic        dmem_req_valid_o;
    logic        dmem_req_ready_i;
    logic [63:0] dmem_addr_o;
    logic        dmem_wen_o;
    logic [63:0] dmem_wdata_o;
    logic [7:0]  dmem_wstrb_o;
    logic        dmem_resp_valid_i;
    logic [63:0] dmem_rdata_i;
    logic        reg_we_lsu_o;
    logic [4:0]  reg_waddr_lsu_o;
    logic [63:0] reg_wdata_lsu_o;
    logic        lsu_stall_o;
    logic [1:0]  lsu_err_o;

    always #5 clk = ~clk;

    ysyx_22050019_lsu #(.DATA_W(64), .TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mem_valid_i       (mem_valid_i),
        .mem_wen_i         (mem_wen_i),
        .funct3_i          (funct3_i),
        .addr_i            (addr_i),
        .wdata_i           (wdata_i),
        .rd_i              (rd_i),
        .dmem_req_valid_o  (dmem_req_valid_o),
        .dmem_req_ready_i  (dmem_req_ready_i),
        .dmem_addr_o       (dmem_addr_o),
        .dmem_wen_o        (dmem_wen_o),
        .dmem_wdata_o      (dmem_wdata_o),
        .dmem_wstrb_o      (dmem_wstrb_o),
        .dmem_resp_valid_i (dmem_resp_valid_i),
        .dmem_rdata_i      (dmem_rdata_i),
        .reg_we_lsu_o      (reg_we_lsu_o),
        .reg_waddr_lsu_o   (reg_waddr_lsu_o),
        .reg_wdata_lsu_o   (reg_wdata_lsu_o),
        .lsu_stall_o       (lsu_stall_o),
        .lsu_err_o         (lsu_err_o)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int we_cnt = 0;

    always @(negedge clk) if (reg_we_lsu_o === 1'b1) we_cnt++;

    // Observations recorded by run_op
    logic        o_pre_stall;
    logic        o_pre_req;
    int          o_bad;
    logic [63:0] o_addr;
    logic        o_wen;
    logic [63:0] o_dwdata;
    logic [7:0]  o_wstrb;
    logic        o_we;
    logic [4:0]  o_waddr;
    logic [63:0] o_rwdata;
    logic        o_we_after;

    logic [7:0]  mem [0:127];

    function automatic logic [7:0] m_strb(input logic [2:0] f3,
                                          input logic [2:0] off);
        int n;
        int m;
        logic [7:0] r;
        n = 1 << f3[1:0];
        m = ((1 << n) - 1) << off;
        r = m[7:0];
        return r;
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] f3,
                                           input int base);
        int n;
        logic [63:0] v;
        n = 1 << f3[1:0];
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mem[base + k];
        if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    function automatic logic [63:0] m_word(input int w);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = mem[w*8 + k];
        return v;
    endfunction

    // Drives one aligned op through the bus handshake; entered and left at posedge+1.
    task automatic run_op(input logic wen, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [4:0] rd, input logic [63:0] rdata,
                          input int rdy_dly, input int rsp_dly);
        mem_valid_i = 1'b1;
        mem_wen_i   = wen;
        funct3_i    = f3;
        addr_i      = addr;
        wdata_i     = wdata;
        rd_i        = rd;
        #1;
        o_pre_stall = lsu_stall_o;
        o_pre_req   = dmem_req_valid_o;
        @(posedge clk); #1;
        o_addr   = dmem_addr_o;
        o_wen    = dmem_wen_o;
        o_dwdata = dmem_wdata_o;
        o_wstrb  = dmem_wstrb_o;
        o_bad    = 0;
        for (int i = 0; i <= rdy_dly; i++) begin
            dmem_req_ready_i = (i == rdy_dly);
            #1;
            if (dmem_req_valid_o !== 1'b1 || lsu_stall_o !== 1'b1 ||
                dmem_addr_o !== o_addr || dmem_wen_o !== o_wen ||
                dmem_wdata_o !== o_dwdata || dmem_wstrb_o !== o_wstrb)
                o_bad++;
            @(posedge clk); #1;
        end
        dmem_req_ready_i = 1'b0;
        for (int j = 0; j <= rsp_dly; j++) begin
            dmem_resp_valid_i = (j == rsp_dly);
            dmem_rdata_i = (j == rsp_dly) ? rdata : {$urandom, $urandom};
            #1;
            if (dmem_req_valid_o !== 1'b0 ||
                lsu_stall_o !== (j != rsp_dly))
                o_bad++;
            @(posedge clk); #1;
        end
        dmem_resp_valid_i = 1'b0;
        mem_valid_i       = 1'b0;
        o_we     = reg_we_lsu_o;
        o_waddr  = reg_waddr_lsu_o;
        o_rwdata = reg_wdata_lsu_o;
        @(posedge clk); #1;
        o_we_after = reg_we_lsu_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({dmem_req_valid_o, lsu_stall_o, reg_we_lsu_o, lsu_err_o} !== 5'b0) begin
            $display("FAIL reset_ctl: got %b want 00000",
                     {dmem_req_valid_o, lsu_stall_o, reg_we_lsu_o, lsu_err_o});
        end else n_pass++;
        n_chk++;
        if (dmem_addr_o !== 64'd0 || dmem_wdata_o !== 64'd0 ||
            dmem_wstrb_o !== 8'd0 || dmem_wen_o !== 1'b0) begin
            $display("FAIL reset_req: got addr %h data %h strb %h want 0",
                     dmem_addr_o, dmem_wdata_o, dmem_wstrb_o);
        end else n_pass++;
        n_chk++;
        if (reg_waddr_lsu_o !== 5'd0 || reg_wdata_lsu_o !== 64'd0) begin
            $display("FAIL reset_wb: got %h/%h want 0",
                     reg_waddr_lsu_o, reg_wdata_lsu_o);
        end else n_pass++;
        rst_n = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lb();
        int w0;
        w0 = we_cnt;
        run_op(1'b0, 3'b000, 64'h8000_0003, 64'd0, 5'd7,
               64'h0000_0000_8000_0000, 0, 0);
        n_chk++;
        if (o_pre_stall !== 1'b1 || o_pre_req !== 1'b0 || o_bad != 0) begin
            $display("FAIL lb_hs: got stall %b req %b bad %0d want 1 0 0",
                     o_pre_stall, o_pre_req, o_bad);
        end else n_pass++;
        n_chk++;
        if (o_addr !== 64'h8000_0000 || o_wen !== 1'b0) begin
            $display("FAIL lb_req: got %h wen %b want 80000000 0", o_addr, o_wen);
        end else n_pass++;
        n_chk++;
        if (o_we !== 1'b1 || o_waddr !== 5'd7 ||
            o_rwdata !== 64'hFFFF_FFFF_FFFF_FF80) begin
            $display("FAIL lb_wb: got we %b rd %0d data %h want 1 7 ffffffffffffff80",
                     o_we, o_waddr, o_rwdata);
        end else n_pass++;
        n_chk++;
        if (o_we_after !== 1'b0 || we_cnt - w0 != 1) begin
            $display("FAIL lb_pulse: got after %b pulses %0d want 0 1",
                     o_we_after, we_cnt - w0);
        end else n_pass++;
    endtask

    task automatic test_sh();
        int w0;
        w0 = we_cnt;
        run_op(1'b1, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 5'd3,
               64'h1234_5678_9ABC_DEF0, 1, 1);
        n_chk++;
        if (o_wstrb !== 8'hC0 || o_dwdata !== 64'hBEEF_0000_0000_0000) begin
            $display("FAIL sh_lane: got strb %h data %h want c0 beef000000000000",
                     o_wstrb, o_dwdata);
        end else n_pass++;
        n_chk++;
        if (o_addr !== 64'h8000_0000 || o_wen !== 1'b1 || o_bad != 0) begin
            $display("FAIL sh_req: got %h wen %b bad %0d want 80000000 1 0",
                     o_addr, o_wen, o_bad);
        end else n_pass++;
        n_chk++;
        if (o_we !== 1'b0 || we_cnt != w0) begin
            $display("FAIL sh_nowb: got we %b pulses %0d want 0 0",
                     o_we, we_cnt - w0);
        end else n_pass++;
    endtask

    task automatic test_lwu_delay();
        run_op(1'b0, 3'b110, 64'h8000_0004, 64'd0, 5'd12,
               64'hDEAD_BEEF_0000_0000, 3, 2);
        n_chk++;
        if (o_bad != 0) begin
            $display("FAIL lwu_hold: got %0d bad cycles want 0", o_bad);
        end else n_pass++;
        n_chk++;
        if (o_we !== 1'b1 || o_waddr !== 5'd12 ||
            o_rwdata !== 64'h0000_0000_DEAD_BEEF) begin
            $display("FAIL lwu_wb: got we %b rd %0d data %h want 1 12 00000000deadbeef",
                     o_we, o_waddr, o_rwdata);
        end else n_pass++;
    endtask

    task automatic test_misaligned();
        logic [2:0]  f3s [5] = '{3'b010, 3'b001, 3'b110, 3'b011, 3'b111};
        logic [63:0] ads [5] = '{64'h8000_0002, 64'h8000_0001,
                                 64'h8000_0003, 64'h8000_0004, 64'h8000_0000};
        int w0;
        w0 = we_cnt;
        for (int i = 0; i < 5; i++) begin
            mem_valid_i = 1'b1;
            mem_wen_i   = 1'b0;
            funct3_i    = f3s[i];
            addr_i      = ads[i];
            rd_i        = 5'd4;
            #1;
            n_chk++;
            if (lsu_stall_o !== 1'b0 || dmem_req_valid_o !== 1'b0) begin
                $display("FAIL mis_idle%0d: got stall %b req %b want 0 0",
                         i, lsu_stall_o, dmem_req_valid_o);
            end else n_pass++;
            @(posedge clk); #1;
            mem_valid_i = 1'b0;
            #1;
            n_chk++;
            if (lsu_err_o !== 2'b01 || dmem_req_valid_o !== 1'b0 ||
                lsu_stall_o !== 1'b0) begin
                $display("FAIL mis_err%0d: got err %b req %b stall %b want 01 0 0",
                         i, lsu_err_o, dmem_req_valid_o, lsu_stall_o);
            end else n_pass++;
            @(posedge clk); #1;
            n_chk++;
            if (lsu_err_o !== 2'b00 || dmem_req_valid_o !== 1'b0) begin
                $display("FAIL mis_clr%0d: got err %b req %b want 00 0",
                         i, lsu_err_o, dmem_req_valid_o);
            end else n_pass++;
        end
        n_chk++;
        if (we_cnt != w0) begin
            $display("FAIL mis_nowb: got %0d pulses want 0", we_cnt - w0);
        end else n_pass++;
    endtask

    task automatic test_timeout(input logic in_resp);
        int w0;
        int bad;
        w0  = we_cnt;
        bad = 0;
        mem_valid_i = 1'b1;
        mem_wen_i   = 1'b0;
        funct3_i    = 3'b011;
        addr_i      = 64'h8000_0010;
        rd_i        = 5'd21;
        @(posedge clk); #1;
        if (in_resp) begin
            dmem_req_ready_i = 1'b1;
            @(posedge clk); #1;
            dmem_req_ready_i = 1'b0;
        end
        for (int i = 0; i < TO; i++) begin
            #1;
            if (lsu_stall_o !== 1'b1 || dmem_req_valid_o !== !in_resp ||
                lsu_err_o !== 2'b00)
                bad++;
            @(posedge clk); #1;
        end
        mem_valid_i = 1'b0;
        #1;
        n_chk++;
        if (bad != 0) begin
            $display("FAIL to_wait%0d: got %0d bad cycles want 0", in_resp, bad);
        end else n_pass++;
        n_chk++;
        if (lsu_err_o !== 2'b10 || dmem_req_valid_o !== 1'b0 ||
            lsu_stall_o !== 1'b0) begin
            $display("FAIL to_err%0d: got err %b req %b stall %b want 10 0 0",
                     in_resp, lsu_err_o, dmem_req_valid_o, lsu_stall_o);
        end else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (lsu_err_o !== 2'b00 || we_cnt != w0) begin
            $display("FAIL to_end%0d: got err %b pulses %0d want 00 0",
                     in_resp, lsu_err_o, we_cnt - w0);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = we_cnt;
        mem_valid_i = 1'b1;
        mem_wen_i   = 1'b0;
        funct3_i    = 3'b000;
        addr_i      = 64'h8000_0021;
        rd_i        = 5'd9;
        @(posedge clk); #1;
        dmem_req_ready_i = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n             = 1'b0;
        mem_valid_i       = 1'b0;
        dmem_resp_valid_i = 1'b1;
        dmem_rdata_i      = ~64'd0;
        #1;
        n_chk++;
        if (dmem_req_valid_o !== 1'b0 || lsu_stall_o !== 1'b0 ||
            dmem_addr_o !== 64'd0 || dmem_wstrb_o !== 8'd0) begin
            $display("FAIL rstmid_out: got req %b stall %b addr %h strb %h want 0",
                     dmem_req_valid_o, lsu_stall_o, dmem_addr_o, dmem_wstrb_o);
        end else n_pass++;
        @(posedge clk); #1;
        dmem_resp_valid_i = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (we_cnt != w0 || reg_we_lsu_o !== 1'b0 || lsu_err_o !== 2'b00 ||
            reg_wdata_lsu_o !== 64'd0) begin
            $display("FAIL rstmid_wb: got pulses %0d err %b data %h want 0",
                     we_cnt - w0, lsu_err_o, reg_wdata_lsu_o);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        int loads;
        int w0;
        w0    = we_cnt;
        loads = 0;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 40; t++) begin
            logic        wen;
            logic [2:0]  f3;
            logic [4:0]  rd;
            logic [63:0] wd;
            logic [63:0] ea;
            logic [63:0] exp_ld;
            int w, n, off, base;
            wen = 1'($urandom_range(0, 1));
            f3  = wen ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            n   = 1 << f3[1:0];
            off = ($urandom_range(0, 7) / n) * n;
            w   = $urandom_range(0, 15);
            base = w * 8 + off;
            ea  = 64'h8000_0000 + 64'(base);
            wd  = {$urandom, $urandom};
            rd  = 5'($urandom_range(1, 31));
            exp_ld = m_load(f3, base);
            run_op(wen, f3, ea, wd, rd, m_word(w),
                   $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
            n_chk++;
            if (o_bad != 0 || o_addr !== (ea & ~64'd7) || o_wen !== wen) begin
                $display("FAIL rnd_req%0d: got addr %h wen %b bad %0d want %h %b 0",
                         t, o_addr, o_wen, o_bad, ea & ~64'd7, wen);
            end else n_pass++;
            if (wen) begin
                n_chk++;
                if (o_wstrb !== m_strb(f3, 3'(off)) ||
                    o_dwdata !== (wd << (8 * off)) || o_we !== 1'b0) begin
                    $display("FAIL rnd_st%0d: got strb %h data %h we %b want %h %h 0",
                             t, o_wstrb, o_dwdata, o_we, m_strb(f3, 3'(off)),
                             wd << (8 * off));
                end else n_pass++;
                for (int k = 0; k < n; k++) mem[base + k] = wd[8*k +: 8];
            end else begin
                loads++;
                n_chk++;
                if (o_we !== 1'b1 || o_waddr !== rd || o_rwdata !== exp_ld ||
                    o_we_after !== 1'b0) begin
                    $display("FAIL rnd_ld%0d: got we %b rd %0d data %h want 1 %0d %h",
                             t, o_we, o_waddr, o_rwdata, rd, exp_ld);
                end else n_pass++;
            end
        end
        n_chk++;
        if (we_cnt - w0 != loads) begin
            $display("FAIL rnd_pulses: got %0d want %0d", we_cnt - w0, loads);
        end else n_pass++;
    endtask

    initial begin
        rst_n             = 1'b1;
        mem_valid_i       = 1'b0;
        mem_wen_i         = 1'b0;
        funct3_i          = 3'b000;
        addr_i            = 64'd0;
        wdata_i           = 64'd0;
        rd_i              = 5'd0;
        dmem_req_ready_i  = 1'b0;
        dmem_resp_valid_i = 1'b0;
        dmem_rdata_i      = 64'd0;
        test_reset();
        test_lb();
        test_sh();
        test_lwu_delay();
        test_misaligned();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ysyx_22050019_lsu.md
Name: ysyx_22050019_lsu

Overview:
Load/store unit of the 5-stage RV64 core. It sits between EX_MEM and MEM_WB. It takes one memory op from EX, runs a valid/ready request and response transaction on the data-memory port, and aligns and extends load data. It produces the LSU write-back triple (reg_we/waddr/wdata) and the stall that freezes upstream stages and MEM_WB (mem_wb_stall) while an access is in flight.

Parameters:
DATA_W, 64, data bus width; only 64 is supported.
TIMEOUT, 256, max cycles waiting in REQ or RESP before a bus error; 0 disables the timeout.

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous, active-high reset (the name is historical; high = reset)
mem_valid_i  in  1  EX presents a load or store this cycle
mem_wen_i  in  1  1 = store, 0 = load
funct3_i  in  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
addr_i  in  64  effective byte address
wdata_i  in  64  store data, LSB-justified
rd_i  in  5  load destination register
dmem_req_valid_o  out  1  request valid
dmem_req_ready_i  in  1  request accepted
dmem_addr_o  out  64  8-byte-aligned address (addr[2:0] = 0)
dmem_wen_o  out  1  write request
dmem_wdata_o  out  64  store data shifted to its byte lane
dmem_wstrb_o  out  8  byte strobes
dmem_resp_valid_i  in  1  read data valid / write ack
dmem_rdata_i  in  64  read data, aligned word
reg_we_lsu_o  out  1  load result valid; 1-cycle pulse
reg_waddr_lsu_o  out  5  load rd
reg_wdata_lsu_o  out  64  extended load data
lsu_stall_o  out  1  freeze upstream stages and MEM_WB
lsu_err_o  out  2  1-cycle pulse: 01 misaligned, 10 timeout

Behaviour:
- Reset: state IDLE; all outputs and internal registers 0; timeout counter 0. Reset mid-transaction abandons the op; any dmem_resp_valid_i seen in IDLE is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If mem_valid_i is 1 and the access is aligned, capture wen, funct3, addr[2:0], rd, and the shifted wdata/wstrb, then go to REQ.
  - Misaligned means H with addr[0] != 0, W/WU with addr[1:0] != 0, or D with addr[2:0] != 0. A misaligned op issues no request, pulses lsu_err_o = 01 on the next cycle, and stays in IDLE.
- REQ:
  - dmem_req_valid_o = 1, with addr/wen/wdata/wstrb held stable until dmem_req_ready_i.
  - On ready, go to RESP.
- RESP:
  - dmem_req_valid_o = 0.
  - On dmem_resp_valid_i, go to IDLE. For a load, register reg_we_lsu_o = 1, reg_waddr_lsu_o = rd, and reg_wdata_lsu_o = the extended value. Stores produce no register write.
- Strobes: B 0x01, H 0x03, W 0x0F, D 0xFF, each shifted left by addr[2:0]. dmem_wdata_o = wdata_i << (8*addr[2:0]).
- Load extract: dmem_rdata_i >> (8*addr[2:0]), truncated to size. Zero-extend for BU/HU/WU; sign-extend otherwise. funct3 = 111 is treated as misaligned.
- reg_we_lsu_o is high for exactly one cycle per load. It is 0 for non-memory instructions; the EXU path into MEM_WB is separate.
- lsu_stall_o (combinational):
  - 1 when in REQ.
  - 1 when in RESP without dmem_resp_valid_i.
  - 1 when in IDLE with an aligned mem_valid_i.
  - 0 otherwise.
- Latency: accept at edge T0, REQ in cycle T0→T1. With ready in that cycle and resp_valid in the next, reg_we_lsu_o is high in the cycle after T2. Minimum is 3 cycles from accept to result.
- Timeout: the counter clears on each state entry and increments each cycle in REQ or RESP.
  - At TIMEOUT, go to IDLE, pulse lsu_err_o = 10, and write no register.
  - If ready/resp and the timeout occur in the same cycle, ready/resp wins.
- The upstream must hold mem_valid_i and its operands stable while lsu_stall_o = 1. A new op is accepted only in IDLE.

Decomposition:
- Shared package ysyx_22050019_defs holds:
  - funct3 load/store encodings
  - FSM state encoding (2 bits)
  - lsu_err codes
  - strobe base masks
- One natural sub-module, ysyx_22050019_lsu_align. It is purely combinational and generates store strobe/data and load extract/extension from funct3 and addr[2:0]. The FSM, timeout counter, and output registers stay in the top module.

Test Plan:
- LB at addr 0x8000_0003, rdata 0x0000_0000_8000_0000 -> wstrb unused, reg_wdata_lsu_o = 0xFFFF_FFFF_FFFF_FF80, rd written, one pulse.
- SH at addr 0x8000_0006, wdata 0xBEEF -> dmem_wstrb_o = 0xC0, dmem_wdata_o = 0xBEEF_0000_0000_0000, dmem_addr_o = 0x8000_0000, reg_we_lsu_o stays 0.
- LWU at addr 0x...4, rdata 0xDEAD_BEEF_0000_0000, ready delayed 3 cycles and resp delayed 2 more -> stall held high throughout, req fields stable, result 0x0000_0000_DEAD_BEEF.
- LW at addr 0x...2 -> no dmem_req_valid_o, lsu_err_o = 01 for one cycle, no stall after the accept cycle.
- TIMEOUT = 4, ready never asserted -> after 4 REQ cycles lsu_err_o = 10, return to IDLE, no register write.
- rst_n asserted while in RESP, then resp_valid arrives -> outputs 0, reg_we_lsu_o never pulses.
